// File: rtl/easyaxi_rd_mst.sv
// Single-outstanding AXI read master: accepts one user read command, issues AR,
// collects R beats, and reports a one-cycle completion with response/error status.
module easyaxi_rd_mst #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8,
   parameter int DATA_W = 32,
   parameter int TO_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ID_W-1:0]   cmd_id,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [2:0]        cmd_size,
   input  logic [1:0]        cmd_burst,
   output logic              axi_mst_arvalid,
   input  logic              axi_mst_arready,
   output logic [ID_W-1:0]   axi_mst_arid,
   output logic [ADDR_W-1:0] axi_mst_araddr,
   output logic [LEN_W-1:0]  axi_mst_arlen,
   output logic [2:0]        axi_mst_arsize,
   output logic [1:0]        axi_mst_arburst,
   input  logic              axi_mst_rvalid,
   output logic              axi_mst_rready,
   input  logic [DATA_W-1:0] axi_mst_rdata,
   input  logic [1:0]        axi_mst_rresp,
   input  logic              axi_mst_rlast,
   output logic              beat_valid,
   output logic [DATA_W-1:0] beat_data,
   output logic [LEN_W-1:0]  beat_idx,
   output logic              done_valid,
   output logic [1:0]        done_resp,
   output logic [LEN_W:0]    done_beats,
   output logic              done_last_err,
   output logic              done_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Idle count at which the next idle cycle completes the timeout.
   localparam logic [7:0] TO_LIM = 8'(TO_CYC - 1);
   localparam logic [1:0] RESP_OKAY = 2'b00;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ID_W-1:0]     id_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [LEN_W-1:0]    len_r;
   logic [2:0]          size_r;
   logic [1:0]          burst_r;
   logic [LEN_W:0]      cnt_r;
   logic [1:0]          resp_r;
   logic [7:0]          to_cnt_r;
   logic                last_err_r;
   logic                timeout_r;

   logic                cmd_hs_s;
   logic                ar_hs_s;
   logic                r_hs_s;
   logic                len_hit_s;
   logic                r_end_s;
   logic                to_hit_s;
   logic                in_done_s;

   // Handshake and termination decode.
   always_comb begin
      cmd_ready = rst_n & enable & (state_r == ST_IDLE);
      cmd_hs_s  = cmd_valid & cmd_ready;
      ar_hs_s   = (state_r == ST_AR) & axi_mst_arready;
      r_hs_s    = (state_r == ST_R) & axi_mst_rvalid;
      len_hit_s = (cnt_r == {1'b0, len_r});
      r_end_s   = r_hs_s & (axi_mst_rlast | len_hit_s);
      to_hit_s  = (state_r == ST_R) & ~axi_mst_rvalid & (to_cnt_r == TO_LIM);
      in_done_s = (state_r == ST_DONE);
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_hs_s) state_nxt_s = ST_AR;
            else          state_nxt_s = ST_IDLE;
         end
         ST_AR: begin
            if (ar_hs_s) state_nxt_s = ST_R;
            else         state_nxt_s = ST_AR;
         end
         ST_R: begin
            if (r_end_s || to_hit_s) state_nxt_s = ST_DONE;
            else                     state_nxt_s = ST_R;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Command latch; held until the next command so the AR payload stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_r    <= '0;
         addr_r  <= '0;
         len_r   <= '0;
         size_r  <= 3'd0;
         burst_r <= 2'd0;
      end else if (cmd_hs_s) begin
         id_r    <= cmd_id;
         addr_r  <= cmd_addr;
         len_r   <= cmd_len;
         size_r  <= cmd_size;
         burst_r <= cmd_burst;
      end
   end

   // Beat counter, sticky response, idle timer and completion flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= '0;
         resp_r     <= RESP_OKAY;
         to_cnt_r   <= 8'd0;
         last_err_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else if (ar_hs_s) begin
         cnt_r      <= '0;
         resp_r     <= RESP_OKAY;
         to_cnt_r   <= 8'd0;
         last_err_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else if (r_hs_s) begin
         cnt_r    <= cnt_r + {{LEN_W{1'b0}}, 1'b1};
         to_cnt_r <= 8'd0;
         if ((resp_r == RESP_OKAY) && (axi_mst_rresp != RESP_OKAY)) resp_r <= axi_mst_rresp;
         // rlast and the length count must agree on the terminating beat.
         if (r_end_s) last_err_r <= axi_mst_rlast ^ len_hit_s;
      end else if (state_r == ST_R) begin
         to_cnt_r <= to_cnt_r + 8'd1;
         if (to_hit_s) timeout_r <= 1'b1;
      end
   end

   // Channel and report outputs, all forced to zero outside their phase.
   always_comb begin
      axi_mst_arvalid = (state_r == ST_AR);
      axi_mst_arid    = id_r;
      axi_mst_araddr  = addr_r;
      axi_mst_arlen   = len_r;
      axi_mst_arsize  = size_r;
      axi_mst_arburst = burst_r;
      axi_mst_rready  = (state_r == ST_R);
      beat_valid      = r_hs_s;
      beat_data       = r_hs_s ? axi_mst_rdata : '0;
      beat_idx        = r_hs_s ? cnt_r[LEN_W-1:0] : '0;
      done_valid      = in_done_s;
      done_resp       = in_done_s ? resp_r : 2'b00;
      done_beats      = in_done_s ? cnt_r : '0;
      done_last_err   = in_done_s & last_err_r;
      done_timeout    = in_done_s & timeout_r;
   end

endmodule

// File: doc/easyaxi_rd_mst.md
EASYAXI_RD_MST -- requirements
Module: easyaxi_rd_mst

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of the AXI ID.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the AXI address.
REQ-003 SHALL have parameter LEN_W, default 8, width of the burst length.
REQ-004 SHALL have parameter DATA_W, default 32, width of the read data.
REQ-005 SHALL have parameter TO_CYC, default 255, maximum R-channel idle cycles before timeout (8-bit counter).
REQ-006 SHALL have port clk, input, 1, clock; rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, which permits command acceptance.
REQ-008 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_id (in, ID_W), cmd_addr (in, ADDR_W), cmd_len (in, LEN_W), cmd_size (in, 3) and cmd_burst (in, 2), forming the user read command.
REQ-009 SHALL have ports axi_mst_arvalid (out, 1), axi_mst_arready (in, 1), axi_mst_arid (out, ID_W), axi_mst_araddr (out, ADDR_W), axi_mst_arlen (out, LEN_W), axi_mst_arsize (out, 3) and axi_mst_arburst (out, 2).
REQ-010 SHALL have ports axi_mst_rvalid (in, 1), axi_mst_rready (out, 1), axi_mst_rdata (in, DATA_W), axi_mst_rresp (in, 2) and axi_mst_rlast (in, 1).
REQ-011 SHALL have ports beat_valid (out, 1), beat_data (out, DATA_W) and beat_idx (out, LEN_W), reporting each received beat.
REQ-012 SHALL have ports done_valid (out, 1), done_resp (out, 2), done_beats (out, LEN_W+1), done_last_err (out, 1) and done_timeout (out, 1), reporting transaction completion.

Function
REQ-013 SHALL implement the FSM states IDLE, AR, R and DONE, with a single outstanding transaction.
REQ-014 SHALL drive cmd_ready = enable & (state==IDLE), combinationally.
REQ-015 SHALL, on a cmd handshake, latch id/addr/len/size/burst and go IDLE->AR on the next cycle; the payload SHALL be held stable until the AR handshake.
REQ-016 SHALL drive axi_mst_arvalid high exactly while in AR, never drop it before arready, and drive the AR payload from the latched values.
REQ-017 SHALL, on the AR handshake (arvalid & arready), go AR->R and clear the beat counter, the sticky response and the timeout counter.
REQ-018 SHALL drive axi_mst_rready high exactly while in R.
REQ-019 SHALL, on each R handshake, set beat_valid for that same cycle (combinational) with beat_data=rdata and beat_idx=beat counter, then increment the beat counter.
REQ-020 SHALL make the sticky response OKAY(0) at AR handshake; the first non-OKAY rresp received SHALL be captured, and later beats SHALL NOT overwrite it.
REQ-021 SHALL end the transaction at the first R handshake where rlast=1 or beat counter==latched len, going R->DONE.
REQ-022 SHALL set done_last_err when (rlast=1 and counter!=len) or (counter==len and rlast=0) on the terminating beat.
REQ-023 SHALL, in R, increment the 8-bit timeout counter on each cycle without an R handshake and reset it on a handshake; reaching TO_CYC SHALL force R->DONE with done_timeout=1.
REQ-024 SHALL keep DONE for exactly one cycle, with done_valid=1, done_resp=sticky response, done_beats=beats received (0..len+1) and the error flags, then return to IDLE.
REQ-025 SHALL NOT time out in AR (the AXI valid rule forbids dropping arvalid).
REQ-026 SHALL NOT let a deassertion of enable abort a transaction in progress; it SHALL only block a new cmd handshake.
REQ-027 SHALL treat an R handshake arriving while not in R as impossible (rready=0) and SHALL ignore rvalid outside R.
REQ-028 SHALL keep done_* outputs 0 whenever done_valid=0.

Reset
REQ-029 SHALL, on rst_n low, immediately enter IDLE and set every output to 0: arvalid, rready, beat_valid, done_valid, all payloads and flags.
REQ-030 SHALL, on reset mid-transaction, abandon the transaction with no done_valid, and be ready for a command on the first cycle after release (if enable=1).

Verification
REQ-031 SHALL pass this scenario: cmd id=1 addr=0x0 len=3, arready asserted after 2 cycles, slave returns 4 OKAY beats data 1..4 with rlast on the 4th -> beat_idx 0..3, done_resp=0, done_beats=4, no error flags.
REQ-032 SHALL pass this scenario: cmd addr=0x10 len=3, slave answers with 4 DECERR beats (rresp=3) -> done_resp=3, done_beats=4.
REQ-033 SHALL pass this scenario: len=3, slave asserts rlast on beat 1 -> DONE after 2 beats, done_last_err=1, done_beats=2.
REQ-034 SHALL pass this scenario: len=1, beat0 SLVERR(2) then beat1 OKAY with rlast -> done_resp=2.
REQ-035 SHALL pass this scenario: AR accepted, rvalid never asserted -> done_timeout=1 and done_beats=0 exactly TO_CYC cycles after entering R, then return to IDLE.
REQ-036 SHALL pass this scenario: rst_n pulsed low during R after 1 beat -> all outputs 0 during reset, no done_valid, and a new cmd accepted after release.
